// File: rtl/rv32_bus_responder.sv
// rv32_bus_responder: arbitrates instr/data bus requests onto one synchronous RAM port with wait states.
// Define RV32_BUS_RANGE_CHECK_EN to fault out-of-range addresses instead of aliasing them.
module rv32_bus_responder #(
  parameter int MEM_WORDS = 2048,
  parameter int WAIT_STATES = 1,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   instr_address_in,
  input  logic          instr_read_in,
  output logic [31:0]   instr_read_value_out,
  output logic          instr_ready_out,
  input  logic [31:0]   data_address_in,
  input  logic          data_read_in,
  input  logic          data_write_in,
  input  logic [3:0]    data_write_mask_in,
  input  logic [31:0]   data_write_value_in,
  output logic [31:0]   data_read_value_out,
  output logic          data_ready_out,
  output logic [AW-1:0] mem_address_out,
  output logic          mem_read_out,
  output logic          mem_write_out,
  output logic [3:0]    mem_write_mask_out,
  output logic [31:0]   mem_write_value_out,
  input  logic [31:0]   mem_read_value_in,
  output logic          fault_out
);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic gnt_q, gnt_d, last_q, last_d, wr_q, wr_d, flt_q, flt_d, first_q, first_d;
  logic [31:0] cap_q, cap_d, ival_q, ival_d, dval_q, dval_d;
  logic ireq, dreq, pick, issue, go, wr, oor, resp, dok;
  logic [31:0] addr, rv;
  logic unused_bits;
  assign ireq = instr_read_in;
  assign dreq = data_read_in | data_write_in;
  // grant select: 1 = data; on a tie serve the port that lost last time
  assign pick = dreq & (~ireq | ~last_q);
  assign addr = pick ? data_address_in : instr_address_in;
  assign wr = pick & data_write_in;
  assign issue = reset_n & (state_q == IDLE) & (ireq | dreq);
`ifdef RV32_BUS_RANGE_CHECK_EN
  assign oor = |(addr >> (AW + 2));
`else
  assign oor = 1'b0;
`endif
  assign unused_bits = ^{addr[1:0], addr >> (AW + 2)};
  assign go = issue & ~oor;
  assign mem_read_out = go & ~wr;
  assign mem_write_out = go & wr;
  assign mem_address_out = go ? addr[AW+1:2] : '0;
  assign mem_write_mask_out = mem_write_out ? data_write_mask_in : 4'd0;
  assign mem_write_value_out = mem_write_out ? data_write_value_in : 32'd0;
  assign resp = state_q == RESPOND;
  assign instr_ready_out = resp & ~gnt_q & ireq;
  assign data_ready_out = resp & gnt_q & dreq;
  // with zero wait states the response lands in the same cycle the backend data arrives
  assign rv = flt_q ? 32'd0 : first_q ? mem_read_value_in : cap_q;
  assign dok = data_ready_out & ~wr_q;
  assign instr_read_value_out = instr_ready_out ? rv : ival_q;
  assign data_read_value_out = dok ? rv : dval_q;
  assign fault_out = flt_q & (instr_ready_out | data_ready_out);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    last_d = last_q;
    wr_d = wr_q;
    flt_d = flt_q;
    first_d = issue;
    cap_d = first_q ? mem_read_value_in : cap_q;
    ival_d = instr_read_value_out;
    dval_d = data_read_value_out;
    if (issue) begin
      gnt_d = pick;
      last_d = pick;
      wr_d = wr;
      flt_d = oor;
      cnt_d = 4'(WAIT_STATES) - 4'd1;
      state_d = (WAIT_STATES > 0) ? WAIT : RESPOND;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd0) ? RESPOND : WAIT;
    end else if (resp) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      gnt_q <= 1'b0;
      last_q <= 1'b0;
      wr_q <= 1'b0;
      flt_q <= 1'b0;
      first_q <= 1'b0;
      cap_q <= 32'd0;
      ival_q <= 32'd0;
      dval_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      wr_q <= wr_d;
      flt_q <= flt_d;
      first_q <= first_d;
      cap_q <= cap_d;
      ival_q <= ival_d;
      dval_q <= dval_d;
    end
  end
endmodule

// File: doc/rv32_bus_responder.md
# rv32_bus_responder

Responder end of the core's instruction and data bus handshake: accepts `instr_read` and `data_read`/`data_write` requests, arbitrates them onto one single-ported synchronous memory backend, inserts a configurable number of wait states, and returns one-cycle `*_ready` pulses with read data. It sits between the rv32 core's fetch/mem-stage bus ports and the on-chip RAM. The core holds each request stable and stalls while a request is asserted and its ready is low.

## Interface
Parameters:
- `MEM_WORDS`, 2048: backend depth in 32-bit words; must be a power of two. `AW = $clog2(MEM_WORDS)`.
- `WAIT_STATES`, 1: extra cycles between issue and response; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr_address_in`  in  32  fetch byte address.
- `instr_read_in`  in  1  fetch request, held until ready.
- `instr_read_value_out`  out  32  fetch data; valid while `instr_ready_out`.
- `instr_ready_out`  out  1  one-cycle fetch completion.
- `data_address_in`  in  32  load/store byte address.
- `data_read_in`  in  1  load request.
- `data_write_in`  in  1  store request.
- `data_write_mask_in`  in  4  byte enables; bit n selects bits 8n+7:8n.
- `data_write_value_in`  in  32  store data.
- `data_read_value_out`  out  32  load data; valid while `data_ready_out`.
- `data_ready_out`  out  1  one-cycle load/store completion.
- `mem_address_out`  out  AW  backend word address.
- `mem_read_out`  out  1  backend read strobe.
- `mem_write_out`  out  1  backend write strobe.
- `mem_write_mask_out`  out  4  backend byte enables.
- `mem_write_value_out`  out  32  backend write data.
- `mem_read_value_in`  in  32  backend read data, valid the cycle after `mem_read_out`.
- `fault_out`  out  1  one-cycle out-of-range flag; only with `RV32_BUS_RANGE_CHECK_EN`.

## Operation
- FSM states: IDLE, WAIT, RESPOND. Reset state: IDLE.
- IDLE, request pending: grant one port and issue the backend strobe combinationally in the same cycle.
  - Word address is `address[AW+1:2]`; `address[1:0]` is ignored.
  - Latch the grant, then go to WAIT if `WAIT_STATES > 0`, else go to RESPOND.
- WAIT: a 4-bit counter loads `WAIT_STATES-1` on issue and decrements each cycle. At 0, go to RESPOND.
- RESPOND: capture `mem_read_value_in` into the read-data register on issue+1. Assert the granted port's ready only if its request is still asserted. Return to IDLE.
- Arbitration on simultaneous instr and data requests: grant the port not granted last. `last_grant` resets to INSTR, so the first tie goes to data. A lone request is always granted.
- `data_read_in` and `data_write_in` both high: treat as a write. No read data is guaranteed.
- Request dropped mid-transaction (core flush): the backend access still completes and the write is committed. Ready is suppressed and no response is owed.
- A request still high in the IDLE cycle after RESPOND is a new transaction.

## Timing
- Request first seen in IDLE at cycle N: strobe at N, ready at N+1+WAIT_STATES.
- Minimum issue-to-issue spacing is WAIT_STATES+2 cycles.
- Reset values: all ready outputs, strobes and `fault_out` are 0. Read-value outputs, `mem_address_out`, mask and write value are all 0.
- Strobes are high for exactly one cycle per transaction. Ready outputs are high for at most one cycle. The two ready outputs are never high together.
- Read-value outputs hold their last captured value between responses.
- Reset asserted mid-transaction: return to IDLE immediately, drop the pending response, and do not retry.

## Configuration
- `RV32_BUS_RANGE_CHECK_EN` defined: an address with any bit above `AW+1` set is out of range.
  - No backend strobe is issued.
  - The normal latency still applies.
  - The response returns read value 0 and pulses `fault_out` together with ready.
- Not defined: upper address bits are ignored, so addresses alias modulo MEM_WORDS*4. `fault_out` is tied to 0.

## Test plan
- WAIT_STATES=1, fetch 0x0000_0010 with mem word 4 = 0x0051_3093 -> `mem_read_out` at N, `instr_ready_out` at N+2 with value 0x0051_3093.
- Store 0xAABB_CCDD with mask 4'b0100 to 0x24, then load 0x24 from a prior value of 0 -> load returns 0x00BB_0000.
- Instr and data requests asserted together from reset, both held -> data is served first, then instr. Ready pulses are WAIT_STATES+2 cycles apart.
- Drop `instr_read_in` during WAIT -> no `instr_ready_out`. The next fetch to the same address is reissued and completes normally.
- `reset_n` low during WAIT -> all outputs are 0 immediately. The request after release is served with full latency.
- With `RV32_BUS_RANGE_CHECK_EN`, MEM_WORDS=2048, load 0x0001_0000 -> no strobe; ready, `fault_out`=1 and value 0. Without the macro, the same load returns word 0.
